// File: rtl/lcd_feed_sched.sv
// lcd_feed_sched: FIFO-buffered pacer for LCD block codes (init/row/page idle slots); 1-cycle registered slot output.
// In_Ready = !full and full-FIFO pushes are dropped; `define LCD_FEED_STATS_EN adds the Page_Count output.
module lcd_feed_sched #(
   parameter int            DW         = 2,
   parameter int            FIFO_DEPTH = 8,
   parameter int            INIT_GAP   = 7,
   parameter int            ROW_LEN    = 16,
   parameter int            ROW_GAP    = 1,
   parameter int            PAGE_LEN   = 64,
   parameter int            PAGE_GAP   = 8,
   parameter logic [DW-1:0] FILL       = '0
) (
   input  logic                          LcdFeed_clk,
   input  logic                          LcdFeed_rst_n,
   input  logic                          Enable,
   input  logic [DW-1:0]                 In_Data,
   input  logic                          In_Valid,
   output logic                          In_Ready,
   output logic [DW-1:0]                 Lcd_Data,
   output logic                          Lcd_Valid,
   output logic                          Lcd_Gap,
   output logic                          Underrun,
   output logic [$clog2(FIFO_DEPTH):0]   Level
`ifdef LCD_FEED_STATS_EN
   ,
   output logic [15:0]                   Page_Count
`endif
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int GMX1 = (INIT_GAP > ROW_GAP) ? INIT_GAP : ROW_GAP;
   localparam int GMAX = (GMX1 > PAGE_GAP) ? GMX1 : PAGE_GAP;
   localparam int GW   = $clog2(GMAX + 1);
   localparam int RW   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int PW   = (PAGE_LEN > 1) ? $clog2(PAGE_LEN) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_STREAM,
      ST_ROW_GAP,
      ST_PAGE_GAP
   } state_t;

   state_t        state_q;
   logic [GW-1:0] gap_cnt_q;
   logic [RW-1:0] row_cnt_q;
   logic [PW-1:0] page_cnt_q;

   logic [DW-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;
   logic          full, empty, push, pop;

   assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign push     = In_Valid && !full;
   assign pop      = (state_q == ST_STREAM) && Enable && !empty;
   assign In_Ready = !full;
   assign Level    = count_q;

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage is not reset; occupancy and pointers alone define validity.
   always_ff @(posedge LcdFeed_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= In_Data;
      end
   end

   always_ff @(posedge LcdFeed_clk or negedge LcdFeed_rst_n) begin
      if (!LcdFeed_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

`ifdef LCD_FEED_STATS_EN
   logic [15:0] page_count_q;
   assign Page_Count = page_count_q;
`endif

   always_ff @(posedge LcdFeed_clk or negedge LcdFeed_rst_n) begin
      if (!LcdFeed_rst_n) begin
         state_q    <= ST_IDLE;
         gap_cnt_q  <= '0;
         row_cnt_q  <= '0;
         page_cnt_q <= '0;
         Lcd_Data   <= '0;
         Lcd_Valid  <= 1'b0;
         Lcd_Gap    <= 1'b0;
         Underrun   <= 1'b0;
`ifdef LCD_FEED_STATS_EN
         page_count_q <= '0;
`endif
      end else if (!Enable) begin
         state_q    <= ST_IDLE;
         gap_cnt_q  <= '0;
         row_cnt_q  <= '0;
         page_cnt_q <= '0;
         Lcd_Valid  <= 1'b0;
         Lcd_Gap    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               Lcd_Valid <= 1'b0;
               Lcd_Gap   <= 1'b0;
               Underrun  <= 1'b0;
               gap_cnt_q <= '0;
               state_q   <= ST_INIT;
            end
            ST_INIT, ST_ROW_GAP, ST_PAGE_GAP: begin
               Lcd_Valid <= 1'b0;
               Lcd_Gap   <= 1'b1;
               if (((state_q == ST_INIT)     && (gap_cnt_q == GW'(INIT_GAP - 1))) ||
                   ((state_q == ST_ROW_GAP)  && (gap_cnt_q == GW'(ROW_GAP - 1)))  ||
                   ((state_q == ST_PAGE_GAP) && (gap_cnt_q == GW'(PAGE_GAP - 1)))) begin
                  gap_cnt_q <= '0;
                  state_q   <= ST_STREAM;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            ST_STREAM: begin
               Lcd_Valid <= 1'b1;
               Lcd_Gap   <= 1'b0;
               gap_cnt_q <= '0;
               // An empty slot still advances the counters so the LCD stays aligned.
               if (empty) begin
                  Lcd_Data <= FILL;
                  Underrun <= 1'b1;
               end else begin
                  Lcd_Data <= mem_q[rd_ptr_q];
               end
               if (row_cnt_q == RW'(ROW_LEN - 1)) begin
                  row_cnt_q <= '0;
                  if (page_cnt_q == PW'(PAGE_LEN - 1)) begin
                     page_cnt_q <= '0;
                     state_q    <= ST_PAGE_GAP;
`ifdef LCD_FEED_STATS_EN
                     page_count_q <= page_count_q + 16'd1;
`endif
                  end else begin
                     page_cnt_q <= page_cnt_q + 1'b1;
                     state_q    <= ST_ROW_GAP;
                  end
               end else begin
                  row_cnt_q  <= row_cnt_q + 1'b1;
                  page_cnt_q <= page_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               Lcd_Valid <= 1'b0;
               Lcd_Gap   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_feed_sched.sv
// Bench for lcd_feed_sched: vector table, gap-length sequences, async reset and a randomized run against a slot-schedule model.
module tb_lcd_feed_sched;
   localparam int         DEPTH    = 8;
   localparam int         INIT_GAP = 7;
   localparam int         ROW_LEN  = 16;
   localparam int         ROW_GAP  = 1;
   localparam int         PAGE_LEN = 64;
   localparam int         PAGE_GAP = 8;
   localparam logic [1:0] FILL     = 2'b00;

   logic       clk = 1'b0;
   logic       rst_n, en, vld;
   logic [1:0] din;
   logic       rdy, lvalid, lgap, under;
   logic [1:0] ldata;
   logic [3:0] level;
`ifdef LCD_FEED_STATS_EN
   logic [15:0] page_count;
`endif

   always #5 clk = ~clk;

   lcd_feed_sched dut (
      .LcdFeed_clk   (clk),
      .LcdFeed_rst_n (rst_n),
      .Enable        (en),
      .In_Data       (din),
      .In_Valid      (vld),
      .In_Ready      (rdy),
      .Lcd_Data      (ldata),
      .Lcd_Valid     (lvalid),
      .Lcd_Gap       (lgap),
      .Underrun      (under),
      .Level         (level)
`ifdef LCD_FEED_STATS_EN
      ,
      .Page_Count    (page_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   // Reference model: slot type follows from the edge count since enable.
   bit         m_run;
   int         m_t;
   logic [1:0] m_q[$];
   bit         m_under;
   int         m_pages;
   logic [1:0] m_data;
   bit         m_valid, m_gap;

   // 0 = gap slot, 1 = data slot, 2 = last data slot of a page
   function automatic int slot_kind(int t);
      int rows_pp, rblk, per, s, p, q;
      if (t <= INIT_GAP) return 0;
      rows_pp = PAGE_LEN / ROW_LEN;
      rblk    = ROW_LEN + ROW_GAP;
      per     = PAGE_LEN + (rows_pp - 1) * ROW_GAP + PAGE_GAP;
      s       = t - INIT_GAP - 1;
      p       = s % per;
      if (p < (rows_pp - 1) * rblk) begin
         q = p % rblk;
         return (q < ROW_LEN) ? 1 : 0;
      end
      q = p - (rows_pp - 1) * rblk;
      if (q == ROW_LEN - 1) return 2;
      return (q < ROW_LEN) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_run = 0; m_t = 0; m_under = 0; m_pages = 0;
      m_valid = 0; m_gap = 0; m_data = 2'b00;
   endtask

   task automatic model_edge(bit e, bit v, logic [1:0] d);
      int lvl;
      int k;
      lvl = m_q.size();
      m_valid = 0;
      m_gap   = 0;
      if (!e) begin
         m_run = 0;
      end else if (!m_run) begin
         m_run = 1; m_t = 0; m_under = 0;
      end else begin
         m_t++;
         k = slot_kind(m_t);
         if (k == 0) begin
            m_gap = 1;
         end else begin
            m_valid = 1;
            if (lvl > 0) m_data = m_q.pop_front();
            else begin
               m_data  = FILL;
               m_under = 1;
            end
            if (k == 2) m_pages = (m_pages + 1) % 65536;
         end
      end
      if (v && lvl < DEPTH) m_q.push_back(d);
   endtask

   task automatic check(string name, logic [15:0] got, logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Packed view: {valid, gap, underrun, ready, level[3:0], data}
   task automatic step(bit e, bit v, logic [1:0] d);
      en = e; vld = v; din = d;
      @(posedge clk);
      model_edge(e, v, d);
      #1;
      check("model", {6'b0, lvalid, lgap, under, rdy, level, (m_valid ? ldata : 2'b00)},
            {6'b0, m_valid, m_gap, m_under, (m_q.size() < DEPTH), 4'(m_q.size()),
             (m_valid ? m_data : 2'b00)});
`ifdef LCD_FEED_STATS_EN
      check("page_count", page_count, 16'(m_pages));
`endif
   endtask

   task automatic do_reset(string name);
      rst_n = 1'b0;
      #1;
      check(name, {6'b0, lvalid, lgap, under, rdy, level, ldata}, 16'h0040);
      model_reset();
      #3;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit         en, vld;
      logic [1:0] dat;
      bit         e_valid, e_gap;
      logic [1:0] e_data;
      logic [3:0] e_level;
      bit         e_ready, e_under;
   } vec_t;
   vec_t vt[$];

   task automatic tv(bit e, bit v, logic [1:0] d, bit ev, bit eg, logic [1:0] ed,
                     logic [3:0] el, bit er, bit eu);
      vec_t x;
      x.en = e; x.vld = v; x.dat = d; x.e_valid = ev; x.e_gap = eg;
      x.e_data = ed; x.e_level = el; x.e_ready = er; x.e_under = eu;
      vt.push_back(x);
   endtask

   initial begin
      int vcount, gaps, dslots, n;
      bit hit;
      logic [1:0] codes [8];
      codes[0] = 2'd1; codes[1] = 2'd2; codes[2] = 2'd3; codes[3] = 2'd0;
      codes[4] = 2'd1; codes[5] = 2'd2; codes[6] = 2'd3; codes[7] = 2'd0;

      // Fill with Enable low (9th push dropped), start-up gaps, drain, underrun, clear on re-enable.
      for (int i = 0; i < 8; i++)
         tv(0, 1, codes[i], 0, 0, 2'd0, 4'(i + 1), (i < 7), 0);
      tv(0, 1, 2'd3, 0, 0, 2'd0, 4'd8, 0, 0);
      tv(1, 0, 2'd0, 0, 0, 2'd0, 4'd8, 0, 0);
      for (int i = 0; i < INIT_GAP; i++)
         tv(1, 0, 2'd0, 0, 1, 2'd0, 4'd8, 0, 0);
      for (int i = 0; i < 8; i++)
         tv(1, 0, 2'd0, 1, 0, codes[i], 4'(7 - i), 1, 0);
      tv(1, 0, 2'd0, 1, 0, FILL, 4'd0, 1, 1);
      tv(0, 0, 2'd0, 0, 0, 2'd0, 4'd0, 1, 1);
      tv(1, 0, 2'd0, 0, 0, 2'd0, 4'd0, 1, 0);

      rst_n = 1'b0; en = 1'b0; vld = 1'b0; din = 2'b00;
      model_reset();
      #1;
      check("reset_state", {6'b0, lvalid, lgap, under, rdy, level, ldata}, 16'h0040);
`ifdef LCD_FEED_STATS_EN
      check("reset_page_count", page_count, 16'd0);
`endif
      #20;
      rst_n = 1'b1;

      foreach (vt[i]) begin
         step(vt[i].en, vt[i].vld, vt[i].dat);
         check($sformatf("vec%0d", i),
               {6'b0, lvalid, lgap, under, rdy, level, (vt[i].e_valid ? ldata : 2'b00)},
               {6'b0, vt[i].e_valid, vt[i].e_gap, vt[i].e_under, vt[i].e_ready,
                vt[i].e_level, vt[i].e_data});
      end

      // Continuous alternating supply: gap run lengths before data slots 1, 17, 33, 49, 65.
      do_reset("reset_seq1");
      step(0, 0, 2'b00);
      vcount = 0; gaps = 0;
      for (int i = 0; i < 200; i++) begin
         step(1, 1, (i % 2 == 0) ? 2'b11 : 2'b00);
         if (lgap) gaps++;
         if (lvalid) begin
            vcount++;
            if (vcount == 1)  check("init_gap_len", 16'(gaps), 16'(INIT_GAP));
            if (vcount == 17 || vcount == 33 || vcount == 49)
               check($sformatf("row_gap_len_%0d", vcount), 16'(gaps), 16'(ROW_GAP));
            if (vcount == 65) check("page_gap_len", 16'(gaps), 16'(PAGE_GAP));
            gaps = 0;
         end
      end
      check("seq1_valid_slots", 16'(vcount >= 65), 16'd1);

      // Async reset at page_cnt = 40, then a full INIT gap again.
      do_reset("reset_seq2");
      step(0, 0, 2'b00);
      dslots = 0; hit = 0;
      for (int i = 0; i < 200 && !hit; i++) begin
         step(1, 1, 2'(i));
         if (lvalid) dslots++;
         if (dslots == 40) hit = 1;
      end
      check("reach_page_cnt_40", 16'(hit), 16'd1);
      #1;
      do_reset("async_reset_midpage");
      step(0, 0, 2'b00);
      n = 0;
      for (int i = 0; i < INIT_GAP + 2; i++) begin
         step(1, 1, 2'b11);
         if (lgap) n++;
      end
      check("init_gap_after_reset", {14'b0, lvalid, lgap}, 16'h0002);
      check("init_gap_count_after_reset", 16'(n), 16'(INIT_GAP));

      // Randomized run: bursts at varying supply rates with occasional Enable drops.
      for (int b = 0; b < 20; b++) begin
         int rate;
         rate = $urandom_range(55, 100);
         for (int i = 0; i < 200; i++)
            step($urandom_range(0, 249) != 0, $urandom_range(1, 100) <= rate,
                 2'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
